// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte buffer and launch sequencer that sits directly in front of the UART
// transmitter. Core logic pushes bytes into a circular FIFO with a write
// strobe. The sequencer then hands bytes to the transmitter one at a time.
// Each byte goes out as a single-cycle start pulse with data. The sequencer
// follows the transmitter busy flag through the whole frame before it issues
// the next byte, so producers can burst bytes without polling busy.
//
// Ports
//   clock     system clock, rising edge
//   reset     asynchronous reset, active low (shared with the transmitter)
//   wr_en     write strobe; byte accepted when flush=0 and full=0
//   wr_data   byte to enqueue
//   flush     synchronous clear of FIFO contents and overflow flag
//   full      queue holds DEPTH bytes
//   empty     queue holds no bytes
//   level     queued byte count, 0..DEPTH (excludes the byte in flight)
//   overflow  sticky; a write arrived while full
//   tx_start  one-cycle launch pulse to the transmitter
//   tx_data   launched byte, held until the next launch
//   tx_busy   transmitter busy flag
//   sent      one-cycle pulse when a launched frame completes
//
// States
//   IDLE      | waiting for a queued byte and a quiet transmitter
//   WAIT_BUSY | launched; waiting for the transmitter to raise busy
//   WAIT_DONE | frame in progress; waiting for busy to fall
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              sent
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     count_next;
    logic                push;
    logic                pop;

    // Flags are decoded from the registered count only, so there is no
    // combinational path from any input to any output.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign level = count;

    // A write into a full queue is refused even if a pop happens in the
    // same cycle; the pop frees space only from the next cycle on.
    assign push = wr_en & ~flush & ~full;

    // While sent is high the sequencer is spending its one mandatory IDLE
    // evaluation cycle, so no launch is decided in that cycle.
    assign pop  = (state == IDLE) & ~empty & ~tx_busy & ~flush & ~sent;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count + (ADDR_W + 1)'(1);
                2'b01:   count_next = count - (ADDR_W + 1)'(1);
                default: count_next = count;
            endcase
        end
    end

    // Storage has no reset; stale contents are never visible because the
    // count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    // Launch sequencer. A flush never aborts a frame already launched:
    // the in-flight byte completes and sent still pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            sent     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            sent     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // The transmitter raises busy one cycle after it
                    // samples start, so busy is still low on the first
                    // cycle spent here.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        sent  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Bench for uart_tx_feeder with a transmitter model (4 clocks per bit,
// 10-bit frame) and a serial-line decoder. Accepted bytes go into an
// expected-byte queue; a monitor pops that queue whenever the feeder
// launches and compares the byte. Decoded serial bytes are compared with
// the launch order.
// ---------------------------------------------------------------------------
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              flush = 1'b0;
    logic              force_busy = 1'b0;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              sent;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] exp_q[$];
    logic [7:0] launched_q[$];
    logic       exp_ovf = 1'b0;
    logic       outst   = 1'b0;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .sent     (sent)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model
    logic       busy_m;
    logic [9:0] shreg;
    int         divcnt;
    int         bitcnt;
    logic       line;

    assign tx_busy = busy_m | force_busy;
    assign line    = busy_m ? shreg[0] : 1'b1;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_m <= 1'b0;
            shreg  <= '1;
            divcnt <= 0;
            bitcnt <= 0;
        end else if (!busy_m) begin
            if (tx_start) begin
                shreg  <= {1'b1, tx_data, 1'b0};
                busy_m <= 1'b1;
                divcnt <= 0;
                bitcnt <= 0;
            end
        end else if (divcnt == 3) begin
            divcnt <= 0;
            if (bitcnt == 9) begin
                busy_m <= 1'b0;
            end else begin
                shreg  <= {1'b1, shreg[9:1]};
                bitcnt <= bitcnt + 1;
            end
        end else begin
            divcnt <= divcnt + 1;
        end
    end

    // Serial decoder: start detected at rcnt=0, data bit k sampled mid-bit
    int         rcnt = 0;
    logic       rx_active = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    always @(posedge clock) begin
        if (rst_n) begin
            if (!rx_active) begin
                if (line == 1'b0) begin
                    rx_active = 1'b1;
                    rcnt = 0;
                end
            end else begin
                rcnt++;
                if ((rcnt % 4 == 2) && (rcnt / 4 >= 1) && (rcnt / 4 <= 8))
                    rx_byte[rcnt / 4 - 1] = line;
                if (rcnt == 38) begin
                    chk("rx_stop", int'(line), 1);
                    if (launched_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: got %0h want none", rx_byte);
                    end else begin
                        chk("rx_byte", int'(rx_byte), int'(launched_q.pop_front()));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard: runs 1 time unit after every rising edge
    int cyc = 0;
    initial begin
        int         last_sent = -10;
        logic       start_last = 1'b0;
        logic       sent_last  = 1'b0;
        logic       bm_prev    = 1'b0;
        logic [7:0] last_data  = 8'h00;
        int         pre;
        @(posedge rst_n);
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            pre = exp_q.size();
            if (tx_start) begin
                chk("start_width", int'(start_last), 0);
                chk("launch_gap", int'(cyc - last_sent >= 2), 1);
                chk("launch_busy", int'(bm_prev | force_busy), 0);
                chk("launch_outst", int'(outst), 0);
                chk("flush_no_launch", int'(flush), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_launch: got %0h want none", tx_data);
                end else begin
                    chk("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                end
                launched_q.push_back(tx_data);
                last_data = tx_data;
                outst = 1'b1;
            end else begin
                chk("tx_data_hold", int'(tx_data), int'(last_data));
            end
            if (sent) begin
                chk("sent_width", int'(sent_last), 0);
                chk("sent_outst", int'(outst), 1);
                outst = 1'b0;
                last_sent = cyc;
            end
            if (flush) begin
                exp_q.delete();
                exp_ovf = 1'b0;
            end else if (wr_en) begin
                if (pre < DEPTH) exp_q.push_back(wr_data);
                else exp_ovf = 1'b1;
            end
            chk("level", int'(level), exp_q.size());
            chk("overflow", int'(overflow), int'(exp_ovf));
            chk("full", int'(full), int'(exp_q.size() == DEPTH));
            chk("empty", int'(empty), int'(exp_q.size() == 0));
            start_last = tx_start;
            sent_last  = sent;
            bm_prev    = busy_m;
        end
    end

    task automatic wait_sent(input int bound);
        logic got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(posedge clock);
            #1;
            if (sent) got = 1'b1;
        end
        chk("wait_sent", int'(got), 1);
    endtask

    task automatic drain(input int bound);
        logic done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0 && !outst && launched_q.size() == 0 &&
                !tx_busy && !sent && !rx_active)
                done = 1'b1;
        end
        chk("drain", int'(done), 1);
    endtask

    initial begin
        int n_start;
        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_start", int'(tx_start), 0);
        chk("rst_sent", int'(sent), 0);
        rst_n = 1'b1;

        // Idle 20 cycles
        n_start = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (tx_start) n_start++;
        end
        chk("idle_no_start", n_start, 0);
        chk("idle_tx_data", int'(tx_data), 0);

        // Single byte, launch latency
        @(negedge clock);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(posedge clock);
        #1;
        chk("lat_empty_c1", int'(empty), 0);
        chk("lat_start_c1", int'(tx_start), 0);
        @(negedge clock);
        wr_en = 1'b0;
        @(posedge clock);
        #1;
        chk("lat_start_c2", int'(tx_start), 1);
        chk("lat_data_c2", int'(tx_data), 8'hA5);
        @(posedge clock);
        #1;
        chk("lat_start_c3", int'(tx_start), 0);
        wait_sent(100);
        @(posedge clock);
        #1;
        chk("single_level", int'(level), 0);
        drain(200);

        // Burst of three
        @(negedge clock);
        wr_en = 1'b1;
        wr_data = 8'h01;
        @(negedge clock);
        wr_data = 8'h02;
        @(negedge clock);
        wr_data = 8'h03;
        @(posedge clock);
        #1;
        chk("burst_peak", int'(level), 2);
        @(negedge clock);
        wr_en = 1'b0;
        drain(400);

        // Fill to full with busy held, one extra write
        @(negedge clock);
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
        end
        @(negedge clock);
        wr_en = 1'b0;
        @(posedge clock);
        #1;
        chk("fill_full", int'(full), 1);
        chk("fill_level", int'(level), 16);
        chk("fill_ovf", int'(overflow), 1);
        @(negedge clock);
        force_busy = 1'b0;
        drain(1500);

        // Push and pop in the same cycle with level=1
        @(negedge clock);
        force_busy = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        @(negedge clock);
        wr_en = 1'b0;
        repeat (3) @(negedge clock);
        force_busy = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        @(posedge clock);
        #1;
        chk("pushpop_level", int'(level), 1);
        chk("pushpop_start", int'(tx_start), 1);
        @(negedge clock);
        wr_en = 1'b0;

        // 40 sequential random bytes, pointers wrap
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 200 && full; k++) @(negedge clock);
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clock);
            wr_en = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clock);
        end
        drain(3000);

        // Flush during WAIT_DONE with level=5 and a same-cycle write
        @(negedge clock);
        wr_en = 1'b1;
        wr_data = 8'($urandom);
        @(negedge clock);
        wr_en = 1'b0;
        for (int k = 0; k < 20 && !busy_m; k++) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            @(negedge clock);
        end
        wr_en = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_flush_level", int'(level), 5);
        chk("pre_flush_busy", int'(tx_busy), 1);
        @(negedge clock);
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hFF;
        @(posedge clock);
        #1;
        chk("flush_level", int'(level), 0);
        chk("flush_ovf", int'(overflow), 0);
        @(negedge clock);
        flush = 1'b0;
        wr_en = 1'b0;
        wait_sent(100);
        n_start = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (tx_start) n_start++;
        end
        chk("flush_no_more_start", n_start, 0);
        drain(200);

        // Random traffic with occasional flush
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            wr_en = ($urandom_range(0, 9) == 0);
            wr_data = 8'($urandom);
            flush = ($urandom_range(0, 199) == 0);
        end
        @(negedge clock);
        wr_en = 1'b0;
        flush = 1'b0;
        drain(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
